// File: rtl/qspi_flash_pkg.sv
// Shared types and constants for the QSPI flash slave model.
package qspi_flash_pkg;

  localparam int QSPI_ADDR_W = 24;

  localparam logic [7:0] QSPI_OP_READ  = 8'h03;
  localparam logic [7:0] QSPI_OP_QREAD = 8'hEB;
  localparam logic [7:0] QSPI_OP_QPP   = 8'h32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_S,
    ST_ADDR_Q,
    ST_DUMMY,
    ST_DATA_S,
    ST_DATA_Q,
    ST_DATA_WR,
    ST_IGNORE
  } qspi_state_e;

endpackage

// File: rtl/qspi_flash_slave_sync_edge.sv
// Two-flop synchroniser with one-clk rise/fall pulses on the synchronised level.
module qspi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // Resetting to 0 means a CS held low through reset produces no fall pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/qspi_flash_slave.sv
// QSPI flash slave model: oversampled serial port serving 0x03 / 0xEB reads from a byte array.
// Define QSPI_FLASH_SLAVE_WRITE_EN to accept 0x32 quad page program.
module qspi_flash_slave
  import qspi_flash_pkg::*;
#(
  parameter int    MEM_SZ       = 262144,
  parameter int    DUMMY_CYCLES = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] qspi_io_i,
  input  logic [3:0] qspi_io_o,
  input  logic [3:0] qspi_io_t,
  input  logic       qspi_ck_o,
  input  logic       qspi_cs_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam int         AW         = $clog2(MEM_SZ);
  localparam logic [7:0] ADDR_S_LAST = 8'(QSPI_ADDR_W - 1);
  localparam logic [7:0] ADDR_Q_LAST = 8'(QSPI_ADDR_W / 4 - 1);
  localparam logic [7:0] DUMMY_LAST  = 8'(DUMMY_CYCLES - 1);

  logic ck_rise, ck_fall, cs_rise, cs_fall;
  logic [3:0] io_meta, io_sync;

  qspi_sync_edge u_ck_sync (.clk(clk), .rst(rst), .d(qspi_ck_o), .rise(ck_rise), .fall(ck_fall));
  qspi_sync_edge u_cs_sync (.clk(clk), .rst(rst), .d(qspi_cs_o), .rise(cs_rise), .fall(cs_fall));

  // Released master lines read as 0; same 2-flop latency keeps data aligned with ck edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_meta <= '0;
      io_sync <= '0;
    end else begin
      io_meta <= qspi_io_o & ~qspi_io_t;
      io_sync <= io_meta;
    end
  end

  qspi_state_e            state_q, state_d;
  logic [7:0]             cnt_q, cmd_sr_q, data_sr_q, opcode, rd_data;
  logic [QSPI_ADDR_W-1:0] addr_q;
  logic [3:0]             io_out_q;
  logic                   cmd_err_q, cmd_err_d;

  assign opcode = {cmd_sr_q[6:0], io_sync[0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_err_d = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else if (cs_fall) begin
      state_d = ST_CMD;
    end else if (ck_rise) begin
      case (state_q)
        ST_CMD: if (cnt_q == 8'd7) begin
          if (opcode == QSPI_OP_READ)       state_d = ST_ADDR_S;
          else if (opcode == QSPI_OP_QREAD) state_d = ST_ADDR_Q;
`ifdef QSPI_FLASH_SLAVE_WRITE_EN
          else if (opcode == QSPI_OP_QPP)   state_d = ST_ADDR_S;
`endif
          else begin
            state_d   = ST_IGNORE;
            cmd_err_d = 1'b1;
          end
        end
        ST_ADDR_S: if (cnt_q == ADDR_S_LAST)
          state_d = (cmd_sr_q == QSPI_OP_QPP) ? ST_DATA_WR : ST_DATA_S;
        ST_ADDR_Q: if (cnt_q == ADDR_Q_LAST)
          state_d = (DUMMY_CYCLES == 0) ? ST_DATA_Q : ST_DUMMY;
        ST_DUMMY: if (cnt_q == DUMMY_LAST) state_d = ST_DATA_Q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      cmd_sr_q  <= '0;
      addr_q    <= '0;
      data_sr_q <= '0;
      io_out_q  <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= cmd_err_d;
      if (cs_rise || cs_fall) begin
        cnt_q    <= '0;
        io_out_q <= '0;
      end else begin
        case (state_q)
          ST_CMD, ST_ADDR_S, ST_ADDR_Q, ST_DUMMY: begin
            io_out_q <= '0;
            if (ck_rise) begin
              cnt_q <= (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
              if (state_q == ST_CMD)    cmd_sr_q <= opcode;
              if (state_q == ST_ADDR_S) addr_q   <= {addr_q[QSPI_ADDR_W-2:0], io_sync[0]};
              if (state_q == ST_ADDR_Q) addr_q   <= {addr_q[QSPI_ADDR_W-5:0], io_sync};
            end
          end
          // The byte at addr_q is already in rd_data when its first bit is due.
          ST_DATA_S: if (ck_fall) begin
            if (cnt_q[2:0] == 3'd0) begin
              io_out_q  <= {2'b00, rd_data[7], 1'b0};
              data_sr_q <= {rd_data[6:0], 1'b0};
              addr_q    <= addr_q + QSPI_ADDR_W'(1);
            end else begin
              io_out_q  <= {2'b00, data_sr_q[7], 1'b0};
              data_sr_q <= {data_sr_q[6:0], 1'b0};
            end
            cnt_q <= {5'd0, cnt_q[2:0] + 3'd1};
          end
          ST_DATA_Q: if (ck_fall) begin
            if (!cnt_q[0]) begin
              io_out_q  <= rd_data[7:4];
              data_sr_q <= {rd_data[3:0], 4'h0};
              addr_q    <= addr_q + QSPI_ADDR_W'(1);
            end else begin
              io_out_q  <= data_sr_q[7:4];
            end
            cnt_q <= {7'd0, ~cnt_q[0]};
          end
          ST_DATA_WR: begin
            io_out_q <= '0;
            if (ck_rise) begin
              if (!cnt_q[0]) data_sr_q[7:4] <= io_sync;
              else           addr_q[7:0]    <= addr_q[7:0] + 8'd1;
              cnt_q <= {7'd0, ~cnt_q[0]};
            end
          end
          default: io_out_q <= '0;
        endcase
      end
    end
  end

  logic [7:0] mem [MEM_SZ];

`ifdef QSPI_FLASH_SLAVE_WRITE_EN
  logic wr_en;
  assign wr_en = (state_q == ST_DATA_WR) && ck_rise && cnt_q[0] && !cs_rise && !cs_fall;
`endif

  // NOTE: the array and its read register have no reset; contents must survive rst.
  always_ff @(posedge clk) begin
`ifdef QSPI_FLASH_SLAVE_WRITE_EN
    if (wr_en) mem[addr_q[AW-1:0]] <= {data_sr_q[7:4], io_sync};
`endif
    rd_data <= mem[addr_q[AW-1:0]];
  end

  initial begin
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'h00;
  end

  assign qspi_io_i = io_out_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign cmd_err_o = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_slave.sv
// Self-checking bench: bit-banged QSPI master against a byte-array reference model.
module tb_qspi_flash_slave;
  import qspi_flash_pkg::*;

  localparam int MEM_SZ       = 262144;
  localparam int DUMMY_CYCLES = 4;
  localparam int HALF         = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] qspi_io_i, qspi_io_o, qspi_io_t;
  logic       qspi_ck_o, qspi_cs_o, busy_o, cmd_err_o;

  always #5 clk = ~clk;

  qspi_flash_slave #(.MEM_SZ(MEM_SZ), .DUMMY_CYCLES(DUMMY_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .qspi_io_i(qspi_io_i), .qspi_io_o(qspi_io_o), .qspi_io_t(qspi_io_t),
    .qspi_ck_o(qspi_ck_o), .qspi_cs_o(qspi_cs_o),
    .busy_o(busy_o), .cmd_err_o(cmd_err_o)
  );

  logic [7:0] model_mem [MEM_SZ];
  logic [3:0] stray;
  int n_tests = 0;
  int n_fail  = 0;
  int err_count = 0;

  always @(negedge clk) if (cmd_err_o === 1'b1) err_count++;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          len;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    @(negedge clk);
    qspi_cs_o = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    qspi_cs_o = 1'b1;
    qspi_io_t = 4'hF;
    wait_clk(2 * HALF);
  endtask

  // One serial clock: drive while ck is low, sample the slave just before the rising edge.
  task automatic sclk(input logic [3:0] drv, input logic [3:0] oe, output logic [3:0] smp);
    qspi_io_o = drv;
    qspi_io_t = ~oe;
    wait_clk(HALF);
    smp = qspi_io_i;
    qspi_ck_o = 1'b1;
    wait_clk(HALF);
    qspi_ck_o = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] s;
    for (int i = 7; i >= 0; i--) begin
      sclk({3'b000, b[i]}, 4'b0001, s);
      stray |= s;
    end
  endtask

  task automatic send_addr_s(input logic [23:0] a);
    logic [3:0] s;
    for (int i = 23; i >= 0; i--) begin
      sclk({3'b000, a[i]}, 4'b0001, s);
      stray |= s;
    end
  endtask

  task automatic do_read(input logic [7:0] op, input logic [23:0] addr, input int len,
                         output logic [31:0] got);
    logic [3:0] s;
    got   = '0;
    stray = '0;
    cs_start();
    send_byte(op);
    if (op == QSPI_OP_QREAD) begin
      for (int i = 5; i >= 0; i--) begin
        sclk(addr[4*i +: 4], 4'hF, s);
        stray |= s;
      end
      for (int i = 0; i < DUMMY_CYCLES; i++) begin
        sclk(4'h0, 4'h0, s);
        stray |= s;
      end
      for (int i = 0; i < 2 * len; i++) begin
        sclk(4'h0, 4'h0, s);
        got = {got[27:0], s};
      end
    end else begin
      send_addr_s(addr);
      for (int i = 0; i < 8 * len; i++) begin
        sclk(4'h0, 4'h0, s);
        got = {got[30:0], s[1]};
        stray |= s & 4'b1101;
      end
    end
    cs_end();
  endtask

  function automatic logic [31:0] model_read(input logic [23:0] addr, input int len);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r = {r[23:0], model_mem[(int'(addr) + i) % MEM_SZ]};
    return r;
  endfunction

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] got;
    logic [3:0]  s;
    logic [7:0]  op;
    logic [23:0] addr;
    int          len, e0;

    vecs[0] = '{QSPI_OP_QREAD, 24'h000100, 4, 32'hDEADBEEF};
    vecs[1] = '{QSPI_OP_READ,  24'h000010, 1, 32'h000000A5};
    vecs[2] = '{QSPI_OP_READ,  24'h000102, 2, 32'h0000BEEF};
    vecs[3] = '{QSPI_OP_QREAD, 24'hFC0100, 2, 32'h0000DEAD};
    vecs[4] = '{QSPI_OP_QREAD, 24'h03FFFF, 2, 32'h00005AC3};
    vecs[5] = '{QSPI_OP_READ,  24'hFFFFFF, 2, 32'h00005AC3};

    rst = 1'b1;
    qspi_cs_o = 1'b1;
    qspi_ck_o = 1'b0;
    qspi_io_o = 4'h0;
    qspi_io_t = 4'hF;
    stray = '0;
    wait_clk(4);

    for (int i = 0; i < MEM_SZ; i++) model_mem[i] = 8'($urandom);
    model_mem[24'h100] = 8'hDE; model_mem[24'h101] = 8'hAD;
    model_mem[24'h102] = 8'hBE; model_mem[24'h103] = 8'hEF;
    model_mem[24'h010] = 8'hA5;
    model_mem[MEM_SZ-1] = 8'h5A; model_mem[0] = 8'hC3;
    for (int i = 0; i < MEM_SZ; i++) dut.mem[i] = model_mem[i];

    check("reset_io",      32'(qspi_io_i), 32'h0);
    check("reset_busy",    32'(busy_o),    32'h0);
    check("reset_cmd_err", 32'(cmd_err_o), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_clk(4);
    check("idle_busy", 32'(busy_o), 32'h0);

    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i].op, vecs[i].addr, vecs[i].len, got);
      check($sformatf("vec%0d_data", i), got, vecs[i].exp);
      check($sformatf("vec%0d_stray", i), 32'(stray), 32'h0);
    end

    // Unsupported opcode, with busy rise latency measured from the raw CS fall.
    e0 = err_count;
    stray = '0;
    @(negedge clk) qspi_cs_o = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("busy_rise_early", 32'(busy_o), 32'h0);
    @(posedge clk); #1;
    check("busy_rise", 32'(busy_o), 32'h1);
    wait_clk(HALF);
    send_byte(8'h9F);
    for (int i = 0; i < 8; i++) begin
      sclk(4'h0, 4'h0, s);
      stray |= s;
    end
    check("bad_op_err_pulse", 32'(err_count - e0), 32'd1);
    check("bad_op_io_zero", 32'(stray), 32'h0);
    check("bad_op_busy", 32'(busy_o), 32'h1);
    cs_end();
    check("bad_op_busy_end", 32'(busy_o), 32'h0);
    do_read(QSPI_OP_QREAD, 24'h000100, 2, got);
    check("after_bad_op", got, 32'h0000DEAD);

    // Abort after three address nibbles, busy fall latency from the raw CS rise.
    stray = '0;
    cs_start();
    send_byte(QSPI_OP_QREAD);
    for (int i = 0; i < 3; i++) sclk(4'h7, 4'hF, s);
    wait_clk(4);
    @(negedge clk) qspi_cs_o = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("busy_fall_early", 32'(busy_o), 32'h1);
    @(posedge clk); #1;
    check("busy_fall", 32'(busy_o), 32'h0);
    wait_clk(2 * HALF);
    do_read(QSPI_OP_QREAD, 24'h000000, 4, got);
    check("after_abort", got, model_read(24'h000000, 4));

    // Reset mid-transfer with CS held low: must wait for a fresh CS fall.
    cs_start();
    send_byte(QSPI_OP_QREAD);
    sclk(4'h1, 4'hF, s);
    @(negedge clk) rst = 1'b1;
    wait_clk(2);
    check("midrst_busy", 32'(busy_o), 32'h0);
    check("midrst_io", 32'(qspi_io_i), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_clk(HALF);
    send_byte(QSPI_OP_QREAD);
    check("postrst_no_frame", 32'(busy_o), 32'h0);
    cs_end();
    do_read(QSPI_OP_READ, 24'h000010, 1, got);
    check("postrst_read", got, 32'h000000A5);

    // Quad page program to the last byte of a page.
    e0 = err_count;
    stray = '0;
    cs_start();
    send_byte(QSPI_OP_QPP);
    send_addr_s(24'h0000FF);
    sclk(4'h1, 4'hF, s); sclk(4'h1, 4'hF, s);
    sclk(4'h2, 4'hF, s); sclk(4'h2, 4'hF, s);
    cs_end();
`ifdef QSPI_FLASH_SLAVE_WRITE_EN
    model_mem[24'h0FF] = 8'h11;
    model_mem[24'h000] = 8'h22;
    check("qpp_no_err", 32'(err_count - e0), 32'd0);
`else
    check("qpp_err_pulse", 32'(err_count - e0), 32'd1);
`endif
    do_read(QSPI_OP_READ, 24'h0000FF, 1, got);
    check("qpp_rd_ff", got, model_read(24'h0000FF, 1));
    do_read(QSPI_OP_QREAD, 24'h000000, 1, got);
    check("qpp_rd_00", got, model_read(24'h000000, 1));

    for (int i = 0; i < 10; i++) begin
      op   = ($urandom_range(0, 1) == 1) ? QSPI_OP_QREAD : QSPI_OP_READ;
      len  = $urandom_range(1, 4);
      addr = 24'($urandom);
      if (i % 3 == 0) addr = {addr[23:18], 18'(MEM_SZ - $urandom_range(1, 3))};
      do_read(op, addr, len, got);
      check($sformatf("rand%0d_op%h_a%h", i, op, addr), got, model_read(addr, len));
      check($sformatf("rand%0d_stray", i), 32'(stray), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
